// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported system memory.
// Port 0 is the CPU, port 1 a secondary master (loader / debug). One transaction is in
// flight at a time; each level request becomes one memory access and completes with a
// one-cycle ack carrying the read data.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound read waits to TIMEOUT cycles.
// Timed-out reads complete with rdata all-ones and err=1 and set the sticky
// timeout_flag. Without the macro, reads wait indefinitely and err/timeout_flag are 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pN_rd, pN_wr              level requests, held until pN_ack (rd+wr means write)
//   pN_addr, pN_wdata         request address / write data
//   pN_rdata, pN_ack, pN_err  completion: data valid with ack, err on read timeout
//   mem_rd_en, mem_wr_en      memory strobes
//   mem_addr, mem_wdata       memory address / write data (all-ones / zero when idle)
//   mem_rdata, mem_rd_valid   memory read return
//   busy                      high outside IDLE
//   timeout_flag              sticky read-timeout indicator
module mem_arbiter #(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_rd,
   input  logic          p0_wr,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_ack,
   output logic          p0_err,
   input  logic          p1_rd,
   input  logic          p1_wr,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_ack,
   output logic          p1_err,
   output logic          mem_rd_en,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rd_valid,
   output logic          busy,
   output logic          timeout_flag
);

   typedef enum logic [1:0] {StIdle, StRdWait, StWr, StDone} state_e;

   state_e        state_q, state_d;
   logic          last_q, last_d;   // port granted most recently
   logic          port_q, port_d;   // port owning the current transaction
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          req0, req1, gnt1, gnt_wr, done;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       flag_q, flag_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
`endif

   assign req0 = p0_rd | p0_wr;
   assign req1 = p1_rd | p1_wr;
   // Port 1 wins when it requests alone, or on a tie when port 0 had the last grant.
   assign gnt1   = req1 & (~req0 | ~last_q);
   // A write request takes precedence over a simultaneous read on the same port.
   assign gnt_wr = gnt1 ? p1_wr : p0_wr;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      port_d  = port_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
      flag_d  = flag_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               last_d  = gnt1;
               port_d  = gnt1;
               addr_d  = gnt1 ? p1_addr : p0_addr;
               wdata_d = gnt1 ? p1_wdata : p0_wdata;
               rdata_d = '0;  // writes return zero
               state_d = gnt_wr ? StWr : StRdWait;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         StRdWait: begin
            // Valid data wins over a timeout in the same cycle.
            if (mem_rd_valid) begin
               rdata_d = mem_rdata;
               state_d = StDone;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_q == TimeoutLast) begin
               rdata_d = '1;
               err_d   = 1'b1;
               flag_d  = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         StWr: begin
            state_d = StDone;
         end
         StDone: begin
            // Requests are ignored here; a request still held in IDLE is a new one.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         last_q  <= 1'b1;  // port 0 wins the first tie
         port_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         port_q  <= port_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         err_q  <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         flag_q <= flag_d;
      end
   end
`endif

   assign done      = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign mem_rd_en = (state_q == StRdWait);
   assign mem_wr_en = (state_q == StWr);
   assign mem_addr  = (mem_rd_en | mem_wr_en) ? addr_q : '1;
   assign mem_wdata = mem_wr_en ? wdata_q : '0;

   assign p0_ack   = done & ~port_q;
   assign p1_ack   = done & port_q;
   assign p0_rdata = p0_ack ? rdata_q : '0;
   assign p1_rdata = p1_ack ? rdata_q : '0;

`ifdef MEM_ARB_TIMEOUT_EN
   assign p0_err       = p0_ack & err_q;
   assign p1_err       = p1_ack & err_q;
   assign timeout_flag = flag_q;
`else
   assign p0_err       = 1'b0;
   assign p1_err       = 1'b0;
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed multi-cycle sequences (reset, tie,
// alternation, reset mid-read, optional timeout) followed by a table of single-port
// transactions. Expected acks are queued when requests are driven and popped on ack.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned TbTimeout = 4;
`else
   localparam int unsigned TbTimeout = 64;
`endif

   logic        clk, rst;
   logic        p0_rd, p0_wr, p1_rd, p1_wr;
   logic [15:0] p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic        p0_ack, p1_ack, p0_err, p1_err;
   logic        mem_rd_en, mem_wr_en, mem_rd_valid;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        busy, timeout_flag;

   mem_arbiter #(.AW(16), .DW(32), .TIMEOUT(TbTimeout)) dut (
      .clk(clk), .rst(rst),
      .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
      .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid),
      .busy(busy), .timeout_flag(timeout_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: unwritten word at index i reads {C0FFEE, i}. mem_lat = cycles of
   // mem_rd_en before valid is returned; 0 means never respond.
   logic [31:0] mem_arr [0:255];
   logic        resp_valid, inj_valid, mem_clear;
   int          mem_lat, rd_cnt;
   assign mem_rd_valid = resp_valid | inj_valid;

   always @(posedge clk) begin
      resp_valid <= 1'b0;
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= {24'hC0FFEE, 8'(i)};
         rd_cnt <= 0;
      end else begin
         if (mem_wr_en) mem_arr[mem_addr[7:0]] <= mem_wdata;
         if (mem_rd_en && !resp_valid && mem_lat != 0) begin
            if (rd_cnt + 1 == mem_lat) begin
               resp_valid <= 1'b1;
               mem_rdata  <= mem_arr[mem_addr[7:0]];
               rd_cnt     <= 0;
            end else begin
               rd_cnt <= rd_cnt + 1;
            end
         end else if (!mem_rd_en) begin
            rd_cnt <= 0;
         end
      end
   end

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        port;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          lat;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
      logic [31:0] exp_rdata;
   } vec_t;
   localparam int NumVec = 10;
   vec_t vecs[NumVec];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_all();
      p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
   endtask

   task automatic drive(input logic port, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [31:0] wdata);
      if (!port) begin
         p0_rd = rd; p0_wr = wr; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_rd = rd; p1_wr = wr; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic push_exp(input logic port, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.port = port; e.rdata = rdata; e.err = err;
      sb.push_back(e);
   endtask

   task automatic sb_ack();
      exp_t e;
      check("ack_exclusive", 64'(p0_ack & p1_ack), 64'd0);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_unexpected_ack: got p0_ack=%b p1_ack=%b, expected no ack", p0_ack,
                  p1_ack);
      end else begin
         e = sb.pop_front();
         check("ack_port", 64'(p1_ack), 64'(e.port));
         check("ack_rdata", 64'(e.port ? p1_rdata : p0_rdata), 64'(e.rdata));
         check("ack_err", 64'(e.port ? p1_err : p0_err), 64'(e.err));
         check("other_port_quiet", e.port ? 64'({p0_ack, p0_err, p0_rdata})
                                          : 64'({p1_ack, p1_err, p1_rdata}), 64'd0);
      end
   endtask

   task automatic wait_ack(input int exp_k, input string name);
      int   k;
      logic got;
      k = 0;
      got = 1'b0;
      while (!got && k < 40) begin
         tick();
         k++;
         if (p0_ack || p1_ack) begin
            got = 1'b1;
            sb_ack();
            drop_all();
         end
      end
      check({name, "_seen"}, 64'(got), 64'd1);
      check(name, 64'(k), 64'(exp_k));
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_clear = 1'b1;
      inj_valid = 1'b0;
      drop_all();
      tick();
      tick();
      rst = 1'b0;
      mem_clear = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1);
   end

   initial begin
      int   k, t0, t1, n_ack, last_k, nrd, nwr;
      logic got;
      vec_t v;

      //          port rd    wr    addr      wdata         lat lat nrd nwr rdata
      vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1, 2, 0, 1, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,        1, 3, 2, 0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h0020, 32'h12345678, 1, 2, 0, 1, 32'h0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0020, 32'h0,        1, 3, 2, 0, 32'h12345678};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0020, 32'h0,        3, 5, 4, 0, 32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 16'hFFFE, 32'hA5A5A5A5, 1, 2, 0, 1, 32'h0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 32'h0,        2, 4, 3, 0, 32'hA5A5A5A5};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0030, 32'h0,        1, 3, 2, 0, 32'hC0FFEE30};
      vecs[8] = '{1'b0, 1'b1, 1'b1, 16'h0010, 32'hCAFEF00D, 1, 2, 0, 1, 32'h0};
      vecs[9] = '{1'b1, 1'b1, 1'b0, 16'h0010, 32'h0,        1, 3, 2, 0, 32'hCAFEF00D};

      p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
      mem_lat = 1;
      do_reset();

      // Reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_acks", 64'({p0_ack, p1_ack, p0_err, p1_err}), 64'd0);
      check("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'd0);
      check("rst_strobes", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'hFFFF);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_timeout_flag", 64'(timeout_flag), 64'd0);

      // Tie after reset: port 0 first, port 1 four cycles later
      drive(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 16'h0044, 32'h0);
      push_exp(1'b0, 32'hC0FFEE40, 1'b0);
      push_exp(1'b1, 32'hC0FFEE44, 1'b0);
      t0 = 0; t1 = 0; k = 0;
      while ((t0 == 0 || t1 == 0) && k < 30) begin
         tick();
         k++;
         if (p0_ack || p1_ack) begin
            sb_ack();
            if (p0_ack) begin t0 = k; p0_rd = 1'b0; end
            if (p1_ack) begin t1 = k; p1_rd = 1'b0; end
         end
      end
      check("tie_p0_lat", 64'(t0), 64'd3);
      check("tie_p1_lat", 64'(t1), 64'd7);
      tick();

      // Both ports hold requests: grants alternate 0,1,0,1,0,1
      drive(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 16'h0044, 32'h0);
      for (int i = 0; i < 6; i++)
         push_exp(1'(i % 2), (i % 2 == 1) ? 32'hC0FFEE44 : 32'hC0FFEE40, 1'b0);
      n_ack = 0; k = 0; last_k = 0;
      while (n_ack < 6 && k < 60) begin
         tick();
         k++;
         if (p0_ack || p1_ack) begin
            sb_ack();
            if (n_ack == 0) check("alt_first_lat", 64'(k), 64'd3);
            else check("alt_spacing", 64'(k - last_k), 64'd4);
            last_k = k;
            n_ack++;
            if (n_ack == 6) drop_all();
         end
      end
      check("alt_count", 64'(n_ack), 64'd6);
      tick();

      // Reset while in RD_WAIT, then a stray valid: no ack, next request normal
      mem_lat = 0;
      drive(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0);
      tick();
      tick();
      check("rstmid_pre_busy", 64'(busy), 64'd1);
      check("rstmid_pre_rd_en", 64'(mem_rd_en), 64'd1);
      rst = 1'b1;
      drop_all();
      tick();
      rst = 1'b0;
      inj_valid = 1'b1;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_rd_en", 64'(mem_rd_en), 64'd0);
      got = p0_ack | p1_ack;
      for (int i = 0; i < 6; i++) begin
         tick();
         inj_valid = 1'b0;
         got = got | p0_ack | p1_ack | busy;
      end
      check("rstmid_no_ack", 64'(got), 64'd0);
      mem_lat = 1;
      drive(1'b1, 1'b1, 1'b0, 16'h0044, 32'h0);
      push_exp(1'b1, 32'hC0FFEE44, 1'b0);
      wait_ack(3, "rstmid_next_lat");

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory never answers: ack+err four cycles after RD_WAIT entry
      mem_lat = 0;
      drive(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0);
      push_exp(1'b0, 32'hFFFFFFFF, 1'b1);
      wait_ack(5, "timeout_lat");
      check("timeout_flag_set", 64'(timeout_flag), 64'd1);
      mem_lat = 1;
      drive(1'b1, 1'b1, 1'b0, 16'h0044, 32'h0);
      push_exp(1'b1, 32'hC0FFEE44, 1'b0);
      wait_ack(3, "post_timeout_lat");
      check("timeout_flag_sticky", 64'(timeout_flag), 64'd1);
      do_reset();
      check("timeout_flag_cleared", 64'(timeout_flag), 64'd0);
`endif

      // Table of single-port transactions
      for (int i = 0; i < NumVec; i++) begin
         v = vecs[i];
         mem_lat = v.lat;
         drive(v.port, v.rd, v.wr, v.addr, v.wdata);
         push_exp(v.port, v.exp_rdata, 1'b0);
         k = 0; got = 1'b0; nrd = 0; nwr = 0;
         while (!got && k < 30) begin
            tick();
            k++;
            if (mem_wr_en) begin
               nwr++;
               check("vec_wr_addr", 64'(mem_addr), 64'(v.addr));
               check("vec_wr_data", 64'(mem_wdata), 64'(v.wdata));
            end
            if (mem_rd_en) begin
               nrd++;
               check("vec_rd_addr", 64'(mem_addr), 64'(v.addr));
            end
            if (p0_ack || p1_ack) begin
               got = 1'b1;
               sb_ack();
               drop_all();
            end
         end
         check("vec_ack_seen", 64'(got), 64'd1);
         check("vec_latency", 64'(k), 64'(v.exp_lat));
         check("vec_rd_cycles", 64'(nrd), 64'(v.exp_nrd));
         check("vec_wr_cycles", 64'(nwr), 64'(v.exp_nwr));
         tick();
         check("vec_idle_busy", 64'(busy), 64'd0);
         check("vec_idle_bus", 64'({mem_rd_en, mem_wr_en, mem_addr, mem_wdata}),
               64'({2'b00, 16'hFFFF, 32'h0}));
      end

`ifndef MEM_ARB_TIMEOUT_EN
      check("no_timeout_flag", 64'(timeout_flag), 64'd0);
`endif
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single-ported system memory between the CPU (port 0) and a secondary master such as a loader or debug port (port 1). It sits between both masters and the memory, serialising one transaction at a time. It converts each master's level request into one memory access, and returns a registered one-cycle acknowledge carrying read data. Register-file and program accesses from the CPU are arbitrated identically to secondary-master traffic.

## Interface
Parameters:
- AW, 16, address width
- DW, 32, data width
- TIMEOUT, 64, read-wait cycle limit (used only with MEM_ARB_TIMEOUT_EN), must be 1..255

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- p0_rd / p1_rd  in  1  read request, level, held until ack
- p0_wr / p1_wr  in  1  write request, level, held until ack
- p0_addr / p1_addr  in  AW  byte address
- p0_wdata / p1_wdata  in  DW  write data
- p0_rdata / p1_rdata  out  DW  read data, valid while matching ack=1
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  one-cycle pulse with ack on timed-out read
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_rd_valid  in  1  memory read data valid
- busy  out  1  high in any state other than IDLE
- timeout_flag  out  1  sticky, set on any read timeout, cleared only by rst

## Operation
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE: if any request is present, grant one port. Latch its addr, wdata, direction and port id. Go to WR if wr=1, else RD_WAIT.
- Arbitration: round-robin on `last` (port last granted). If both ports request, grant !last. If one requests, grant it. `last` updates on each grant. Reset value of last=1, so port 0 wins the first tie.
- rd and wr both high on one port: treated as a write.
- RD_WAIT: mem_rd_en=1, mem_addr=latched addr, held every cycle. On mem_rd_valid=1: capture mem_rdata and go to DONE.
- WR: mem_wr_en=1, mem_addr and mem_wdata latched, for exactly one cycle, then DONE.
- DONE: ack=1 for the granted port only. rdata is the captured word, or 0 after a write. Requests are ignored in this cycle. Next state is always IDLE.
- Non-granted port: ack, err and rdata stay 0.
- Outside RD_WAIT/WR: mem_rd_en=0, mem_wr_en=0, mem_addr=all-ones, mem_wdata=0.
- mem_rd_valid outside RD_WAIT is ignored.

## Timing
- Reset values (registered outputs, valid the cycle after rst): state=IDLE, all acks/errs=0, rdata=0, busy=0, timeout_flag=0, memory strobes=0.
- rst mid-transaction: abandoned with no ack. A late mem_rd_valid is ignored.
- Write latency: request seen in IDLE at cycle N → mem_wr_en at N+1 → ack at N+2 → IDLE at N+3.
- Read latency: request at N → mem_rd_en from N+1 → mem_rd_valid at cycle M → ack at M+1. With a 1-cycle memory (valid at N+2), ack is at N+3.
- Back-to-back: minimum issue spacing is 3 cycles (write) or 4 cycles (1-cycle read).
- Masters must drop or change their request in the cycle after ack. A request still held in the IDLE cycle after DONE is a new transaction.
- Starvation bound: with both ports continuously requesting, grants strictly alternate.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to RD_WAIT and increments each RD_WAIT cycle without mem_rd_valid.
  - When the counter reaches TIMEOUT: go to DONE with rdata=all-ones, ack=1 and err=1 for the granted port, and set timeout_flag.
  - mem_rd_valid in the same cycle as the limit wins; the read completes normally.
- Undefined: no counter. RD_WAIT waits indefinitely. err outputs and timeout_flag are tied 0.

## Test plan
- Single port-0 write, addr 0x0010, data 0xDEADBEEF; then a read of 0x0010 with 1-cycle memory → mem_wr_en pulse at N+1 and p0_ack at N+2; read p0_ack at N+3 with p0_rdata=0xDEADBEEF.
- Both ports request reads in the same cycle after reset → port 0 granted first, port 1 granted in the following IDLE. p1_ack arrives 4 cycles after p0_ack.
- Both ports hold requests continuously for 6 transactions → grant order 0,1,0,1,0,1. No port acks twice in a row.
- Port 1 asserts rd and wr together, addr 0x0020, wdata 0x12345678 → single mem_wr_en, no mem_rd_en, p1_ack with p1_rdata=0.
- rst asserted while in RD_WAIT, then mem_rd_valid one cycle later → no ack on either port, busy=0, next request served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, memory never responds → ack+err 4 cycles after RD_WAIT entry, rdata=0xFFFFFFFF, timeout_flag=1 until rst.
